instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Sequences the 16-bit datapath: buffers incoming instructions and steps each through the four control phases.
//  Phases are 0 decode, 1 load regA, 2 load regR, 3 writeback.
//  Drives the 2-bit phase counter and the instruction word consumed by control_unit.
//  Replaces the free-running external counter, so the datapath idles when no work is queued.
//  Sits between the instruction source (valid/ready) and control_unit.
// PARAMETERS
//  INSTR_W    16  instruction word width
//  BUF_DEPTH  2   pending-instruction FIFO entries (>=1)
//  CNT_W      16  width of retired-instruction counter
// PORTS
//  clock          in   1          rising-edge clock
//  reset          in   1          asynchronous, active-high reset
//  instr_in       in   INSTR_W    instruction from source
//  instr_valid    in   1          instr_in valid
//  instr_ready    out  1          FIFO can accept; transfer on valid&&ready at clock edge
//  stall          in   1          hold current phase (datapath not ready)
//  clear          in   1          synchronous abort of current instruction
//  instr_out      out  INSTR_W    instruction in execution (to control_unit inn)
//  counter        out  2          current phase (to control_unit counter)
//  busy           out  1          instruction in execution; control_unit gates on this
//  done           out  1          one-cycle pulse: instruction retired
//  retired_count  out  CNT_W      instructions retired since reset
// BEHAVIOUR
//  Reset (async, immediate):
//   - counter=0, busy=0, done=0, instr_out=0, retired_count=0.
//   - FIFO emptied; instr_ready=0 while reset is high.
//  FIFO:
//   - instr_ready = !full, taken from registered state.
//   - When full, a push in the same cycle as a pop is NOT accepted.
//   - Pushed data is poppable no earlier than the next edge; there is no bypass.
//  FSM states: IDLE, RUN. All outputs are registered.
//   - IDLE & FIFO non-empty: pop into instr_out, set counter=0, busy=1, go to RUN.
//   - RUN & !stall & counter<3: counter+1.
//   - RUN & !stall & counter==3:
//     - done=1 for the next cycle; retired_count+1, wrapping 2^CNT_W-1 -> 0.
//     - If the FIFO is non-empty: pop, counter=0, stay in RUN (no bubble).
//     - Otherwise: busy=0, counter=0, go to IDLE.
//     - instr_out holds its last value in IDLE.
//   - RUN & stall: counter and instr_out hold; FIFO still accepts pushes.
//   - stall is ignored in IDLE.
//   - clear (priority over stall and phase advance):
//     - In RUN: go to IDLE, busy=0, counter=0, no done, retired_count unchanged.
//     - FIFO contents are kept; the next entry may start on the following edge.
//     - clear in IDLE: no pop that cycle.
//  Latency:
//   - Accept edge t with FIFO empty and IDLE: busy=1, counter=0 after edge t+1.
//   - done high during the cycle after edge t+5.
//   - Unstalled throughput: 1 instruction / 4 cycles.
//  Reset mid-instruction: in-flight and buffered instructions are dropped; no done pulse.
// TESTING
//  1 Push 16'h0049 into idle block: busy/counter=0 one edge later; counter 0,1,2,3; done 1 cycle; retired_count=1; back to IDLE.
//  2 Push 3 instrs back-to-back: busy continuously high 12 cycles; counter 0-3 x3; done every 4th cycle; retired_count=3.
//  3 Stall high, push 4 instrs: 1 in execution + 2 buffered accepted; instr_ready=0; 4th held until pop; order preserved.
//  4 Stall 3 cycles at counter=2: counter and instr_out hold; done arrives 3 cycles late.
//  5 Clear at counter=2 with 1 buffered: no done, retired_count unchanged; buffered instr starts with counter=0.
//  6 Async reset at counter=1 with full FIFO: outputs zero immediately; no done; after release ready=1, FIFO empty.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers incoming instructions in a small FIFO and steps
// each one through the four control phases (decode, load regA, load regR,
// writeback) for control_unit. The datapath idles when nothing is queued.
module instr_sequencer #(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               stall,
    input  logic               clear,
    output logic [INSTR_W-1:0] instr_out,
    output logic [1:0]         counter,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired_count
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // FIFO storage and pointers
    logic [INSTR_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] fifo_head;

    // Sequencer state and registered outputs
    state_t             state_q;
    logic [INSTR_W-1:0] instr_out_q;
    logic [1:0]         counter_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   retired_q;

    // Ready comes from registered occupancy only, so a full FIFO refuses a
    // push even when a pop happens on the same edge. Held low during reset.
    assign instr_ready = (occ_q != OCC_FULL) && !reset;
    assign push        = instr_valid && instr_ready;
    assign fifo_empty  = (occ_q == '0);
    assign fifo_head   = mem_q[rd_ptr_q];

    assign instr_out     = instr_out_q;
    assign counter       = counter_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign retired_count = retired_q;

    // Pop decision: start from IDLE, or chain on writeback without a bubble
    always_comb begin
        pop = 1'b0;
        if (!clear && !fifo_empty) begin
            if (state_q == S_IDLE) begin
                pop = 1'b1;
            end else if (!stall && counter_q == 2'd3) begin
                pop = 1'b1;
            end
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO control registers; reset drops all buffered entries
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // FIFO data write; no bypass, entries become poppable after this edge
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_in;
        end
    end

    // Phase sequencer: clear beats stall, stall beats phase advance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_out_q <= '0;
            counter_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            retired_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                if (state_q == S_RUN) begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    counter_q <= '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            instr_out_q <= fifo_head;
                            counter_q   <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!stall) begin
                            if (counter_q != 2'd3) begin
                                counter_q <= counter_q + 2'd1;
                            end else begin
                                done_q    <= 1'b1;
                                retired_q <= retired_q + CNT_W'(1);
                                counter_q <= '0;
                                if (pop) begin
                                    instr_out_q <= fifo_head;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fixed vectors, hand-derived expectations.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        clear;
    logic [15:0] instr_out;
    logic [1:0]  counter;
    logic        busy;
    logic        done;
    logic [15:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    instr_sequencer #(
        .INSTR_W  (16),
        .BUF_DEPTH(2),
        .CNT_W    (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .clear        (clear),
        .instr_out    (instr_out),
        .counter      (counter),
        .busy         (busy),
        .done         (done),
        .retired_count(retired_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling or driving
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t2 [3];
        logic [15:0] t3 [4];
        t2 = '{16'h1111, 16'h2222, 16'h3333};
        t3 = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};

        reset       = 1'b1;
        instr_in    = '0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        clear       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst ready", instr_ready, 0);
        check("rst busy", busy, 0);
        check("rst counter", counter, 0);
        check("rst done", done, 0);
        check("rst instr_out", instr_out, 0);
        check("rst retired", retired_count, 0);
        reset = 1'b0;
        #1;
        check("rst release ready", instr_ready, 1);

        // 1: single instruction
        instr_in = 16'h0049; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t1 busy after accept", busy, 0);
        tick();
        check("t1 busy start", busy, 1);
        check("t1 counter start", counter, 0);
        check("t1 instr_out", instr_out, 16'h0049);
        for (int p = 1; p <= 3; p++) begin
            tick();
            check("t1 counter", counter, 32'(p));
            check("t1 no early done", done, 0);
        end
        tick();
        check("t1 done", done, 1);
        check("t1 busy end", busy, 0);
        check("t1 counter end", counter, 0);
        check("t1 retired", retired_count, 1);
        tick();
        check("t1 done one cycle", done, 0);
        check("t1 instr_out hold", instr_out, 16'h0049);

        // 2: three back-to-back instructions
        instr_in = t2[0]; instr_valid = 1'b1;
        tick();
        instr_in = t2[1];
        tick();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            if (i == 0) instr_in = t2[2];
            if (i == 1) instr_valid = 1'b0;
            check("t2 busy", busy, 1);
            check("t2 counter", counter, 32'(i % 4));
            check("t2 instr_out", instr_out, t2[i / 4]);
            check("t2 done", done, (i % 4 == 0 && i != 0) ? 1 : 0);
        end
        tick();
        check("t2 final done", done, 1);
        check("t2 final busy", busy, 0);
        check("t2 retired", retired_count, 4);

        // 3: stall with four pushes, FIFO fills
        stall = 1'b1;
        instr_in = t3[0]; instr_valid = 1'b1;
        tick();
        instr_in = t3[1];
        tick();
        instr_in = t3[2];
        tick();
        instr_in = t3[3];
        check("t3 full ready", instr_ready, 0);
        check("t3 busy", busy, 1);
        check("t3 counter", counter, 0);
        check("t3 instr_out", instr_out, t3[0]);
        tick();
        tick();
        check("t3 stalled counter", counter, 0);
        check("t3 still full", instr_ready, 0);
        check("t3 stalled instr", instr_out, t3[0]);
        stall = 1'b0;
        tick(); tick(); tick();
        check("t3 counter 3", counter, 3);
        tick();
        check("t3 done 0", done, 1);
        check("t3 second instr", instr_out, t3[1]);
        check("t3 ready after pop", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check("t3 fourth accepted", instr_ready, 0);
        check("t3 counter chain", counter, 1);
        tick(); tick(); tick();
        check("t3 third instr", instr_out, t3[2]);
        check("t3 done 1", done, 1);
        tick(); tick(); tick(); tick();
        check("t3 fourth instr", instr_out, t3[3]);
        check("t3 done 2", done, 1);
        tick(); tick(); tick(); tick();
        check("t3 done 3", done, 1);
        check("t3 busy end", busy, 0);
        check("t3 retired", retired_count, 8);

        // 4: stall three cycles at counter 2
        instr_in = 16'hBEEF; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick(); tick(); tick();
        check("t4 counter 2", counter, 2);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t4 stall counter", counter, 2);
            check("t4 stall instr", instr_out, 16'hBEEF);
            check("t4 stall done", done, 0);
            check("t4 stall busy", busy, 1);
        end
        stall = 1'b0;
        tick();
        check("t4 counter 3", counter, 3);
        tick();
        check("t4 late done", done, 1);
        check("t4 retired", retired_count, 9);
        check("t4 busy end", busy, 0);

        // 5: clear at counter 2 with one buffered
        instr_in = 16'hF00F; instr_valid = 1'b1;
        tick();
        instr_in = 16'h6006;
        tick();
        instr_valid = 1'b0;
        tick(); tick();
        check("t5 counter 2", counter, 2);
        check("t5 instr F", instr_out, 16'hF00F);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5 clear busy", busy, 0);
        check("t5 clear counter", counter, 0);
        check("t5 clear done", done, 0);
        check("t5 clear retired", retired_count, 9);
        tick();
        check("t5 restart busy", busy, 1);
        check("t5 restart counter", counter, 0);
        check("t5 buffered instr", instr_out, 16'h6006);
        tick(); tick(); tick();
        check("t5 counter 3", counter, 3);
        tick();
        check("t5 done", done, 1);
        check("t5 retired", retired_count, 10);

        // 5b: clear in IDLE blocks the pop
        clear = 1'b1;
        instr_in = 16'h4848; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("t5b no pop under clear", busy, 0);
        clear = 1'b0;
        tick();
        check("t5b start busy", busy, 1);
        check("t5b start instr", instr_out, 16'h4848);
        check("t5b start counter", counter, 0);
        tick(); tick(); tick(); tick();
        check("t5b done", done, 1);
        check("t5b retired", retired_count, 11);

        // 6: async reset mid-instruction with full FIFO
        instr_in = 16'h1A1A; instr_valid = 1'b1;
        tick();
        instr_in = 16'h2B2B;
        tick();
        instr_in = 16'h3C3C;
        tick();
        instr_valid = 1'b0;
        check("t6 counter 1", counter, 1);
        check("t6 full", instr_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        check("t6 async busy", busy, 0);
        check("t6 async counter", counter, 0);
        check("t6 async instr_out", instr_out, 0);
        check("t6 async retired", retired_count, 0);
        check("t6 async ready", instr_ready, 0);
        check("t6 async done", done, 0);
        tick();
        tick();
        check("t6 held busy", busy, 0);
        reset = 1'b0;
        #1;
        check("t6 release ready", instr_ready, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6 fifo empty busy", busy, 0);
            check("t6 no done", done, 0);
        end
        check("t6 retired", retired_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
